// File: rtl/tinyriscv_pkg.sv
// ============================================================================
// tinyriscv_pkg -- shared bus widths and debug-arbiter state encoding | rev 1.0
// ============================================================================
`default_nettype none

package tinyriscv_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 1 << RegAddrBus;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STALL = 2'd2,
    RESP  = 2'd3
  } dbg_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_dbg_arb.sv
// ============================================================================
// regfile_dbg_arb -- debug port req/gnt arbiter with write-starvation stall | rev 1.0
// ============================================================================
`default_nettype none

module regfile_dbg_arb
  import tinyriscv_pkg::*;
#(
  parameter int DbgStarveMax = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic core_we,
  input  logic req,
  input  logic wr,
  output logic gnt,
  output logic rvalid,
  output logic stall
);

  localparam int CntW = (DbgStarveMax > 1) ? $clog2(DbgStarveMax) : 1;

  dbg_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rvalid  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rvalid  <= gnt;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          // Reads never conflict with the core; writes must find the ports quiet.
          if (!wr || !core_we) begin
            gnt     = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (!core_we) begin
          gnt     = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CntW'(DbgStarveMax - 1)) begin
          state_d = STALL;
        end
      end
      STALL: begin
        stall = 1'b1;
        if (!core_we) begin
          gnt     = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  a_no_we_in_stall: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == STALL) |-> !core_we);

  a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == WAIT || state_q == STALL) |-> req);

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp -- multi-port GPR file with busy scoreboard and debug port | rev 1.0
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
// ============================================================================
`default_nettype none

module regfile_mp
  import tinyriscv_pkg::*;
#(
  parameter int DataWidth    = RegBus,
  parameter int NumRegs      = RegNum,
  parameter int NumRead      = 2,
  parameter int NumWrite     = 1,
  parameter int DbgStarveMax = 8,
  parameter int AddrW        = $clog2(NumRegs)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumWrite-1:0]           we_i,
  input  logic [NumWrite*AddrW-1:0]     waddr_i,
  input  logic [NumWrite*DataWidth-1:0] wdata_i,
  input  logic [NumRead-1:0]            ren_i,
  input  logic [NumRead*AddrW-1:0]      raddr_i,
  output logic [NumRead*DataWidth-1:0]  rdata_o,
  output logic [NumRead-1:0]            busy_o,
  input  logic                          sb_set_i,
  input  logic [AddrW-1:0]              sb_addr_i,
  input  logic                          dbg_req_i,
  input  logic                          dbg_we_i,
  input  logic [AddrW-1:0]              dbg_addr_i,
  input  logic [DataWidth-1:0]          dbg_wdata_i,
  output logic                          dbg_gnt_o,
  output logic                          dbg_rvalid_o,
  output logic [DataWidth-1:0]          dbg_rdata_o,
  output logic                          dbg_stall_o
);

  logic [DataWidth-1:0] regs [NumRegs];
  logic [NumRegs-1:0]   busy_q;
  logic [NumRegs-1:0]   wr_hit;
  logic [AddrW-1:0]     waddr [NumWrite];
  logic [DataWidth-1:0] wdata [NumWrite];
  logic                 dbg_wr;
  logic [DataWidth-1:0] dbg_rdata_q;

  for (genvar p = 0; p < NumWrite; p++) begin : g_wport
    assign waddr[p] = waddr_i[p*AddrW +: AddrW];
    assign wdata[p] = wdata_i[p*DataWidth +: DataWidth];
  end

  always_comb begin
    wr_hit = '0;
    for (int p = 0; p < NumWrite; p++) begin
      if (we_i[p]) wr_hit[waddr[p]] = 1'b1;
    end
    wr_hit[0] = 1'b0;
  end

  // The arbiter only grants a debug write when no core port is writing.
  assign dbg_wr = dbg_gnt_o && dbg_we_i && (dbg_addr_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
    end else begin
      if (dbg_wr) regs[dbg_addr_i] <= dbg_wdata_i;
      for (int p = 0; p < NumWrite; p++) begin
        if (we_i[p] && (waddr[p] != '0)) regs[waddr[p]] <= wdata[p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_q & ~wr_hit;
      if (sb_set_i && (sb_addr_i != '0)) busy_q[sb_addr_i] <= 1'b1;
    end
  end

  for (genvar r = 0; r < NumRead; r++) begin : g_read
    logic [AddrW-1:0]     addr;
    logic [DataWidth-1:0] rd;
    logic                 bz;

    assign addr = raddr_i[r*AddrW +: AddrW];

    always_comb begin
      rd = '0;
      bz = 1'b0;
      if (ren_i[r] && (addr != '0)) begin
        rd = regs[addr];
        bz = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NumWrite; p++) begin
          if (we_i[p] && (waddr[p] == addr)) rd = wdata[p];
        end
        if (wr_hit[addr]) bz = 1'b0;
`endif
      end
    end

    assign rdata_o[r*DataWidth +: DataWidth] = rd;
    assign busy_o[r]                         = bz;
  end

  regfile_dbg_arb #(
    .DbgStarveMax (DbgStarveMax)
  ) u_dbg_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .core_we (|we_i),
    .req     (dbg_req_i),
    .wr      (dbg_we_i),
    .gnt     (dbg_gnt_o),
    .rvalid  (dbg_rvalid_o),
    .stall   (dbg_stall_o)
  );

  // Response data is captured at grant; writes answer with zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dbg_rdata_q <= '0;
    end else begin
      dbg_rdata_q <= (dbg_gnt_o && !dbg_we_i) ? regs[dbg_addr_i] : '0;
    end
  end

  assign dbg_rdata_o = dbg_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// tb_regfile_mp -- directed scoreboard bench for regfile_mp (NumWrite=2) | rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int SMAX = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NWR-1:0]     we;
  logic [NWR*AW-1:0]  waddr;
  logic [NWR*DW-1:0]  wdata;
  logic [NRD-1:0]     ren;
  logic [NRD*AW-1:0]  raddr;
  logic [NRD*DW-1:0]  rdata;
  logic [NRD-1:0]     busy;
  logic               sb_set;
  logic [AW-1:0]      sb_addr;
  logic               dbg_req, dbg_we;
  logic [AW-1:0]      dbg_addr;
  logic [DW-1:0]      dbg_wdata;
  logic               dbg_gnt, dbg_rvalid, dbg_stall;
  logic [DW-1:0]      dbg_rdata;

  typedef struct {
    string         tag;
    logic [DW-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DataWidth (DW), .NumRegs (32), .NumRead (NRD), .NumWrite (NWR), .DbgStarveMax (SMAX)
  ) dut (
    .clk_i (clk), .rst_i (rst),
    .we_i (we), .waddr_i (waddr), .wdata_i (wdata),
    .ren_i (ren), .raddr_i (raddr), .rdata_o (rdata), .busy_o (busy),
    .sb_set_i (sb_set), .sb_addr_i (sb_addr),
    .dbg_req_i (dbg_req), .dbg_we_i (dbg_we), .dbg_addr_i (dbg_addr),
    .dbg_wdata_i (dbg_wdata), .dbg_gnt_o (dbg_gnt), .dbg_rvalid_o (dbg_rvalid),
    .dbg_rdata_o (dbg_rdata), .dbg_stall_o (dbg_stall)
  );

  task automatic expect_v(input string tag, input logic [DW-1:0] v);
    exp_q.push_back('{tag: tag, val: v});
  endtask

  task automatic check_v(input logic [DW-1:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic clr_in();
    we = '0; waddr = '0; wdata = '0; ren = '0; raddr = '0;
    sb_set = 1'b0; sb_addr = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    ren[p] = 1'b1;
    raddr[p*AW +: AW] = a;
  endtask

  task automatic exp_read(input string tag, input logic [DW-1:0] d, input logic b);
    expect_v({tag, "_data"}, d);
    expect_v({tag, "_busy"}, {31'b0, b});
  endtask

  task automatic obs_read(input int p);
    check_v(rdata[p*DW +: DW]);
    check_v({31'b0, busy[p]});
  endtask

  task automatic exp_dbg(input string tag, input logic g, input logic v,
                         input logic [DW-1:0] d, input logic s);
    expect_v({tag, "_gnt"}, {31'b0, g});
    expect_v({tag, "_rvalid"}, {31'b0, v});
    expect_v({tag, "_rdata"}, d);
    expect_v({tag, "_stall"}, {31'b0, s});
  endtask

  task automatic obs_dbg();
    check_v({31'b0, dbg_gnt});
    check_v({31'b0, dbg_rvalid});
    check_v(dbg_rdata);
    check_v({31'b0, dbg_stall});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clr_in();
    repeat (3) @(negedge clk);
    set_rd(0, 5'd1);
    exp_dbg("reset", 1'b0, 1'b0, '0, 1'b0);
    exp_read("reset_rd", '0, 1'b0);
    #1; obs_dbg(); obs_read(0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      clr_in();
      set_rd(0, AW'(i));
      set_rd(1, AW'(32 - i));
      exp_read("init_p0", '0, 1'b0);
      exp_read("init_p1", '0, 1'b0);
      #1; obs_read(0); obs_read(1);
    end

    @(negedge clk); clr_in(); set_wr(0, 5'd5, 32'hDEADBEEF);
    @(negedge clk); clr_in(); set_rd(0, 5'd5);
    exp_read("wr_x5", 32'hDEADBEEF, 1'b0);
    #1; obs_read(0);
    ren = '0;
    exp_read("ren_off", '0, 1'b0);
    #1; obs_read(0);

    @(negedge clk); clr_in(); set_wr(0, 5'd7, 32'h11); set_wr(1, 5'd7, 32'h22);
    @(negedge clk); clr_in(); set_rd(1, 5'd7);
    exp_read("dual_wr_x7", 32'h22, 1'b0);
    #1; obs_read(1);

    @(negedge clk); clr_in(); set_wr(0, 5'd0, 32'hFF); sb_set = 1'b1; sb_addr = 5'd0;
    @(negedge clk); clr_in(); set_rd(0, 5'd0);
    exp_read("x0", '0, 1'b0);
    #1; obs_read(0);

    @(negedge clk); clr_in(); sb_set = 1'b1; sb_addr = 5'd3;
    @(negedge clk); clr_in(); set_rd(0, 5'd3);
    exp_read("sb_set_x3", '0, 1'b1);
    #1; obs_read(0);
    clr_in(); set_wr(0, 5'd3, 32'h33); sb_set = 1'b1; sb_addr = 5'd3;
    @(negedge clk); clr_in(); set_rd(0, 5'd3);
    exp_read("sb_set_wins", 32'h33, 1'b1);
    #1; obs_read(0);
    set_wr(0, 5'd3, 32'h34);
    @(negedge clk); clr_in(); set_rd(0, 5'd3);
    exp_read("sb_clear", 32'h34, 1'b0);
    #1; obs_read(0);

    @(negedge clk); clr_in(); set_wr(0, 5'd9, 32'h1111);
    @(negedge clk); clr_in(); set_wr(0, 5'd9, 32'hA5A5); set_rd(0, 5'd9);
`ifdef REGFILE_BYPASS_EN
    exp_read("bypass_x9", 32'hA5A5, 1'b0);
`else
    exp_read("bypass_x9", 32'h1111, 1'b0);
`endif
    #1; obs_read(0);
    sb_set = 1'b1; sb_addr = 5'd9;
    @(negedge clk); clr_in(); set_rd(0, 5'd9);
    exp_read("after_x9", 32'hA5A5, 1'b1);
    #1; obs_read(0);
    set_wr(0, 5'd9, 32'h0F0F); set_wr(1, 5'd9, 32'h5A5A); set_rd(1, 5'd9);
`ifdef REGFILE_BYPASS_EN
    exp_read("bypass_hi", 32'h5A5A, 1'b0);
`else
    exp_read("bypass_hi", 32'hA5A5, 1'b1);
`endif
    #1; obs_read(1);
    @(negedge clk); clr_in(); set_rd(0, 5'd9);
    exp_read("commit_hi", 32'h5A5A, 1'b0);
    #1; obs_read(0);

    // Debug write starved by a core writing every cycle.
    @(negedge clk); clr_in(); set_wr(0, 5'd20, 32'hCAFE);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'h1234;
    exp_dbg("dbgw_req", 1'b0, 1'b0, '0, 1'b0);
    #1; obs_dbg();
    for (int k = 0; k < SMAX; k++) begin
      @(negedge clk);
      exp_dbg("dbgw_wait", 1'b0, 1'b0, '0, 1'b0);
      #1; obs_dbg();
    end
    @(negedge clk);
    exp_dbg("dbgw_stall", 1'b0, 1'b0, '0, 1'b1);
    obs_dbg();
    we = '0;
    exp_dbg("dbgw_gnt", 1'b1, 1'b0, '0, 1'b1);
    #1; obs_dbg();
    @(negedge clk); dbg_req = 1'b0; dbg_we = 1'b0;
    exp_dbg("dbgw_resp", 1'b0, 1'b1, '0, 1'b0);
    #1; obs_dbg();
    @(negedge clk); set_rd(0, 5'd4); set_rd(1, 5'd20);
    exp_dbg("dbgw_done", 1'b0, 1'b0, '0, 1'b0);
    exp_read("dbgw_x4", 32'h1234, 1'b0);
    exp_read("dbgw_x20", 32'hCAFE, 1'b0);
    #1; obs_dbg(); obs_read(0); obs_read(1);

    @(negedge clk); clr_in(); dbg_req = 1'b1; dbg_addr = 5'd4;
    exp_dbg("dbgr_gnt", 1'b1, 1'b0, '0, 1'b0);
    #1; obs_dbg();
    @(negedge clk); dbg_req = 1'b0;
    exp_dbg("dbgr_resp", 1'b0, 1'b1, 32'h1234, 1'b0);
    #1; obs_dbg();
    @(negedge clk);
    exp_dbg("dbgr_done", 1'b0, 1'b0, '0, 1'b0);
    #1; obs_dbg();

    // Reset while a debug write is waiting.
    @(negedge clk); clr_in(); set_wr(0, 5'd21, 32'h55);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd6; dbg_wdata = 32'h77;
    repeat (3) @(negedge clk);
    rst = 1'b1; clr_in();
    @(negedge clk); rst = 1'b0;
    exp_dbg("rst_wait_a", 1'b0, 1'b0, '0, 1'b0);
    #1; obs_dbg();
    @(negedge clk); set_rd(0, 5'd6); set_rd(1, 5'd4);
    exp_dbg("rst_wait_b", 1'b0, 1'b0, '0, 1'b0);
    exp_read("rst_x6", '0, 1'b0);
    exp_read("rst_x4", '0, 1'b0);
    #1; obs_dbg(); obs_read(0); obs_read(1);
    @(negedge clk); clr_in(); dbg_req = 1'b1; dbg_addr = 5'd21;
    exp_dbg("rst_idle_gnt", 1'b1, 1'b0, '0, 1'b0);
    #1; obs_dbg();
    @(negedge clk); dbg_req = 1'b0;
    exp_dbg("rst_idle_resp", 1'b0, 1'b1, '0, 1'b0);
    #1; obs_dbg();

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL leftover_expectations observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
